pri_icache_ctrl_responder: RTL and testbench
============================================

Name: pri_icache_ctrl_responder

Overview:
- Per-core responder for the private L1 instruction-cache control interface. One instance sits inside each private L1 icache.
- Receives level requests from the cluster icache control unit: bypass, full flush and selective flush. Sequences the tag-array operations, drains the fetch path and returns acknowledgements.
- Also hosts the L1 statistic counters (hit, transaction, miss, congestion) with their clear and enable controls.

Parameters:
- NB_WAYS, 4, associativity; one tag bank per way.
- NB_SETS, 32, sets per way; must be a power of 2.
- ADDR_W, 32, fetch address width.
- LINE_BYTES, 16, cache line size in bytes; sets OFF_W = log2(LINE_BYTES).
- CNT_W, 32, statistic counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- bypass_req_i  in  1  level: 1 = enter bypass mode, 0 = use the cache
- bypass_ack_o  out  1  level: current effective bypass state
- flush_req_i  in  1  full-flush request, level
- flush_ack_o  out  1  one-cycle done pulse
- sel_flush_req_i  in  1  selective-flush request, level
- sel_flush_addr_i  in  ADDR_W  address whose line is invalidated
- sel_flush_ack_o  out  1  one-cycle done pulse
- fetch_idle_i  in  1  fetch pipeline has no outstanding refill
- ctrl_busy_o  out  1  stalls new fetch acceptance
- tag_req_o  out  NB_WAYS  per-way tag-bank enable
- tag_we_o  out  1  write enable; write data is valid=0
- tag_addr_o  out  SET_W  set index
- tag_rdata_i  in  NB_WAYS*(TAG_W+1)  per way {valid, tag}; 1-cycle read latency
- bypass_o  out  1  drives the fetch mux
- hit_i, miss_i, trans_i, cong_i  in  1 each  event pulses
- clear_regs_i  in  1  clear all counters
- enable_regs_i  in  1  enable counting
- hit_count_o, trans_count_o, miss_count_o, cong_count_o  out  CNT_W each  counter values

Behaviour:
- Widths: SET_W = log2(NB_SETS); TAG_W = ADDR_W - SET_W - OFF_W.
  - Set index = addr[OFF_W+SET_W-1:OFF_W].
  - Tag = addr[ADDR_W-1:OFF_W+SET_W].
- Reset values: all outputs 0, FSM in IDLE, counters 0, arm flags set.
- FSM states: IDLE, DRAIN, FLUSH, SEL_RD, SEL_WR, BYP_SW, DONE.
- IDLE:
  - Request priority: flush > sel_flush > bypass change.
  - A bypass change means bypass_req_i != bypass_ack_o.
  - A flush or sel_flush starts only if its arm flag is set.
  - On an accepted request: capture the operation and sel_flush_addr_i, then go to DRAIN.
- DRAIN:
  - ctrl_busy_o = 1 (it stays 1 in every state except IDLE).
  - Waits for fetch_idle_i, then branches to FLUSH, SEL_RD or BYP_SW.
- FLUSH:
  - Each cycle: tag_req_o all ones, tag_we_o = 1, tag_addr_o = set counter.
  - Set counter runs 0..NB_SETS-1; after the last set, go to DONE.
- SEL_RD: read the captured set with all ways enabled.
- SEL_WR:
  - Compare the read data against the captured tag; hit[w] = valid & tag match.
  - If any way hits: write tag_req_o = hit mask with tag_we_o = 1.
  - If none hits: no access.
  - Go to DONE.
- BYP_SW: bypass_o and bypass_ack_o take the bypass_req_i value sampled at acceptance; go to IDLE (no DONE).
- DONE:
  - Pulse the matching ack for one cycle.
  - Clear that operation's arm flag; go to IDLE.
- Arm flag: set again when the corresponding req is seen low. A held-high req therefore never retriggers.
- Latency with fetch_idle_i = 1:
  - Flush ack comes NB_SETS+2 cycles after acceptance.
  - Sel-flush ack comes 3 cycles after acceptance.
  - Bypass ack changes 2 cycles after acceptance.
- Simultaneous requests: the lower-priority request waits in IDLE. A flush may run while in bypass; the bypass state is unchanged by it.
- Requests dropping mid-operation: the operation still completes; the ack pulse is still issued.
- Asynchronous reset mid-operation: everything returns to reset values; a partial flush is abandoned.
- Counters:
  - Each counter increments by 1 on its event when enable_regs_i = 1.
  - Wrap-around modulo 2^CNT_W.
  - clear_regs_i wins over an increment in the same cycle (result 0).
  - Counters run independently of the FSM.

Decomposition:
- Package pri_icache_ctrl_pkg:
  - FSM state enum.
  - Operation enum: OP_FLUSH, OP_SEL, OP_BYP.
  - Width helper functions for SET_W, TAG_W, OFF_W.
- Sub-module pri_icache_stat_cnt: one counter with inc/clear/enable and wrap-around, instantiated 4 times.

Test Plan:
- Reset, then flush_req_i = 1 with fetch_idle_i = 1 -> tag writes to sets 0..31 on 32 consecutive cycles, all ways enabled; flush_ack_o pulses once 34 cycles after acceptance; no second ack while req stays high.
- Preload set 19, way 2 with tag 0x0E0000 valid; sel_flush addr 0x1C00_0130 -> read of set 19, then a write with tag_req_o = 4'b0100; ack 3 cycles after acceptance. A non-matching address -> no write, ack still issued.
- bypass_req_i = 1 while fetch_idle_i = 0 for 5 cycles -> ctrl_busy_o = 1 throughout; bypass_o and bypass_ack_o rise 2 cycles after idle; req back to 0 -> both fall.
- flush and sel_flush requested in the same cycle -> flush runs first; the sel_flush ack follows after the flush ack.
- Assert rst_i at FLUSH set 10 -> outputs 0 the same cycle; no ack; a new flush restarts from set 0.
- hit_i every cycle for 10 cycles with enable_regs_i = 1, clear_regs_i in cycle 5 -> hit_count_o reads 5 at the end. Counter at 0xFFFF_FFFF plus one event -> 0.

Source files
------------

// File: rtl/pri_icache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pri_icache_ctrl_pkg
// Brief  : Shared types and width helpers for the L1 icache control responder.
// Rev    : 1.0
// ============================================================================
package pri_icache_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_SEL_RD = 3'd3,
        ST_SEL_WR = 3'd4,
        ST_BYP_SW = 3'd5,
        ST_DONE   = 3'd6
    } ctrl_state_e;

    typedef enum logic [1:0] {
        OP_FLUSH = 2'd0,
        OP_SEL   = 2'd1,
        OP_BYP   = 2'd2
    } ctrl_op_e;

    function automatic int off_width(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int set_width(input int nb_sets);
        return $clog2(nb_sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int nb_sets, input int line_bytes);
        return addr_w - set_width(nb_sets) - off_width(line_bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pri_icache_stat_cnt.sv
`default_nettype none
// ============================================================================
// Module : pri_icache_stat_cnt
// Brief  : Wrapping event counter with synchronous clear and count enable.
// Rev    : 1.0
// ============================================================================
module pri_icache_stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    // Clear takes precedence over a coincident event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_enable && i_inc) begin
            o_count <= o_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pri_icache_ctrl_responder.sv
`default_nettype none
// ============================================================================
// Module : pri_icache_ctrl_responder
// Brief  : Per-core L1 icache control responder: flush, selective flush and
//          bypass sequencing, plus the L1 statistic counters.
// Rev    : 1.0
// ============================================================================
module pri_icache_ctrl_responder
    import pri_icache_ctrl_pkg::*;
#(
    parameter  int NB_WAYS    = 4,
    parameter  int NB_SETS    = 32,
    parameter  int ADDR_W     = 32,
    parameter  int LINE_BYTES = 16,
    parameter  int CNT_W      = 32,
    localparam int c_OFF_W    = off_width(LINE_BYTES),
    localparam int c_SET_W    = set_width(NB_SETS),
    localparam int c_TAG_W    = tag_width(ADDR_W, NB_SETS, LINE_BYTES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           bypass_req_i,
    output logic                           bypass_ack_o,
    input  logic                           flush_req_i,
    output logic                           flush_ack_o,
    input  logic                           sel_flush_req_i,
    input  logic [ADDR_W-1:0]              sel_flush_addr_i,
    output logic                           sel_flush_ack_o,
    input  logic                           fetch_idle_i,
    output logic                           ctrl_busy_o,
    output logic [NB_WAYS-1:0]             tag_req_o,
    output logic                           tag_we_o,
    output logic [c_SET_W-1:0]             tag_addr_o,
    input  logic [NB_WAYS*(c_TAG_W+1)-1:0] tag_rdata_i,
    output logic                           bypass_o,
    input  logic                           hit_i,
    input  logic                           miss_i,
    input  logic                           trans_i,
    input  logic                           cong_i,
    input  logic                           clear_regs_i,
    input  logic                           enable_regs_i,
    output logic [CNT_W-1:0]               hit_count_o,
    output logic [CNT_W-1:0]               trans_count_o,
    output logic [CNT_W-1:0]               miss_count_o,
    output logic [CNT_W-1:0]               cong_count_o
);

    ctrl_state_e          r_state;
    ctrl_op_e             r_op;
    logic [c_SET_W-1:0]   r_set;
    logic [c_TAG_W-1:0]   r_tag;
    logic                 r_byp_val;
    logic [c_SET_W:0]     r_flush_cnt;
    logic                 r_flush_arm;
    logic                 r_sel_arm;

    logic [c_SET_W-1:0]   w_addr_set;
    logic [c_TAG_W-1:0]   w_addr_tag;
    logic                 w_bypass_chg;
    logic                 w_accept;
    ctrl_op_e             w_next_op;
    logic [NB_WAYS-1:0]   w_hit;
    logic                 w_unused_off;

    assign w_addr_set   = sel_flush_addr_i[c_OFF_W +: c_SET_W];
    assign w_addr_tag   = sel_flush_addr_i[ADDR_W-1 -: c_TAG_W];
    assign w_unused_off = ^sel_flush_addr_i[c_OFF_W-1:0];
    assign w_bypass_chg = (bypass_req_i != bypass_ack_o);

    generate
        for (genvar w = 0; w < NB_WAYS; w++) begin : g_way
            logic [c_TAG_W:0] w_entry;
            assign w_entry  = tag_rdata_i[w*(c_TAG_W+1) +: (c_TAG_W+1)];
            assign w_hit[w] = w_entry[c_TAG_W] && (w_entry[c_TAG_W-1:0] == r_tag);
        end
    endgenerate

    always_comb begin
        w_accept  = 1'b1;
        w_next_op = OP_BYP;
        if (flush_req_i && r_flush_arm) begin
            w_next_op = OP_FLUSH;
        end else if (sel_flush_req_i && r_sel_arm) begin
            w_next_op = OP_SEL;
        end else if (!w_bypass_chg) begin
            w_accept  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= ST_IDLE;
            r_op            <= OP_FLUSH;
            r_set           <= '0;
            r_tag           <= '0;
            r_byp_val       <= 1'b0;
            r_flush_cnt     <= '0;
            r_flush_arm     <= 1'b1;
            r_sel_arm       <= 1'b1;
            bypass_ack_o    <= 1'b0;
            bypass_o        <= 1'b0;
            flush_ack_o     <= 1'b0;
            sel_flush_ack_o <= 1'b0;
            ctrl_busy_o     <= 1'b0;
            tag_req_o       <= '0;
            tag_we_o        <= 1'b0;
            tag_addr_o      <= '0;
        end else begin
            flush_ack_o     <= 1'b0;
            sel_flush_ack_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= w_next_op;
                        r_set       <= w_addr_set;
                        r_tag       <= w_addr_tag;
                        r_byp_val   <= bypass_req_i;
                        ctrl_busy_o <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fetch_idle_i) begin
                        case (r_op)
                            OP_FLUSH: begin
                                r_flush_cnt <= '0;
                                r_state     <= ST_FLUSH;
                            end
                            OP_SEL: begin
                                tag_req_o  <= '1;
                                tag_we_o   <= 1'b0;
                                tag_addr_o <= r_set;
                                r_state    <= ST_SEL_RD;
                            end
                            default: r_state <= ST_BYP_SW;
                        endcase
                    end
                end
                ST_FLUSH: begin
                    // Counter MSB marks that every set has already been issued
                    if (r_flush_cnt[c_SET_W]) begin
                        tag_req_o   <= '0;
                        tag_we_o    <= 1'b0;
                        flush_ack_o <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        tag_req_o   <= '1;
                        tag_we_o    <= 1'b1;
                        tag_addr_o  <= r_flush_cnt[c_SET_W-1:0];
                        r_flush_cnt <= r_flush_cnt + (c_SET_W+1)'(1);
                    end
                end
                ST_SEL_RD: begin
                    tag_req_o <= '0;
                    r_state   <= ST_SEL_WR;
                end
                ST_SEL_WR: begin
                    tag_req_o       <= w_hit;
                    tag_we_o        <= |w_hit;
                    sel_flush_ack_o <= 1'b1;
                    r_state         <= ST_DONE;
                end
                ST_BYP_SW: begin
                    bypass_o     <= r_byp_val;
                    bypass_ack_o <= r_byp_val;
                    ctrl_busy_o  <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                ST_DONE: begin
                    tag_req_o   <= '0;
                    tag_we_o    <= 1'b0;
                    ctrl_busy_o <= 1'b0;
                    if (r_op == OP_FLUSH) begin
                        r_flush_arm <= 1'b0;
                    end else begin
                        r_sel_arm   <= 1'b0;
                    end
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            // Re-arm only once the requester has released its level
            if (!flush_req_i) begin
                r_flush_arm <= 1'b1;
            end
            if (!sel_flush_req_i) begin
                r_sel_arm <= 1'b1;
            end
        end
    end

    pri_icache_stat_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk(clk_i), .rst(rst_i), .i_clear(clear_regs_i),
        .i_enable(enable_regs_i), .i_inc(hit_i), .o_count(hit_count_o)
    );
    pri_icache_stat_cnt #(.CNT_W(CNT_W)) u_trans_cnt (
        .clk(clk_i), .rst(rst_i), .i_clear(clear_regs_i),
        .i_enable(enable_regs_i), .i_inc(trans_i), .o_count(trans_count_o)
    );
    pri_icache_stat_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk(clk_i), .rst(rst_i), .i_clear(clear_regs_i),
        .i_enable(enable_regs_i), .i_inc(miss_i), .o_count(miss_count_o)
    );
    pri_icache_stat_cnt #(.CNT_W(CNT_W)) u_cong_cnt (
        .clk(clk_i), .rst(rst_i), .i_clear(clear_regs_i),
        .i_enable(enable_regs_i), .i_inc(cong_i), .o_count(cong_count_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pri_icache_ctrl_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_pri_icache_ctrl_responder
// Brief  : Directed self-checking bench for pri_icache_ctrl_responder.
// Rev    : 1.0
// ============================================================================
module tb_pri_icache_ctrl_responder;

    localparam int NB_WAYS = 4;
    localparam int NB_SETS = 32;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 32;
    localparam int SET_W   = 5;
    localparam int TAG_W   = 23;

    logic                           clk;
    logic                           rst_i;
    logic                           bypass_req_i, bypass_ack_o;
    logic                           flush_req_i, flush_ack_o;
    logic                           sel_flush_req_i, sel_flush_ack_o;
    logic [ADDR_W-1:0]              sel_flush_addr_i;
    logic                           fetch_idle_i, ctrl_busy_o;
    logic [NB_WAYS-1:0]             tag_req_o;
    logic                           tag_we_o;
    logic [SET_W-1:0]               tag_addr_o;
    logic [NB_WAYS*(TAG_W+1)-1:0]   tag_rdata_i;
    logic                           bypass_o;
    logic                           hit_i, miss_i, trans_i, cong_i;
    logic                           clear_regs_i, enable_regs_i;
    logic [CNT_W-1:0]               hit_count_o, trans_count_o, miss_count_o, cong_count_o;

    logic                           wrap_inc;
    logic [3:0]                     wrap_count;

    int n_checks = 0;
    int n_errors = 0;

    pri_icache_ctrl_responder #(
        .NB_WAYS(NB_WAYS), .NB_SETS(NB_SETS), .ADDR_W(ADDR_W),
        .LINE_BYTES(16), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .bypass_req_i(bypass_req_i), .bypass_ack_o(bypass_ack_o),
        .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
        .sel_flush_req_i(sel_flush_req_i), .sel_flush_addr_i(sel_flush_addr_i),
        .sel_flush_ack_o(sel_flush_ack_o),
        .fetch_idle_i(fetch_idle_i), .ctrl_busy_o(ctrl_busy_o),
        .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_addr_o(tag_addr_o),
        .tag_rdata_i(tag_rdata_i), .bypass_o(bypass_o),
        .hit_i(hit_i), .miss_i(miss_i), .trans_i(trans_i), .cong_i(cong_i),
        .clear_regs_i(clear_regs_i), .enable_regs_i(enable_regs_i),
        .hit_count_o(hit_count_o), .trans_count_o(trans_count_o),
        .miss_count_o(miss_count_o), .cong_count_o(cong_count_o)
    );

    // Narrow counter instance so wrap-around is reachable in a few cycles
    pri_icache_stat_cnt #(.CNT_W(4)) u_wrap (
        .clk(clk), .rst(rst_i), .i_clear(1'b0), .i_enable(1'b1),
        .i_inc(wrap_inc), .o_count(wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag array model: 1-cycle read latency, writes clear the valid bit
    logic [TAG_W:0] mem [NB_WAYS][NB_SETS];
    logic [TAG_W:0] rd  [NB_WAYS];
    logic           pl_en;
    logic [1:0]     pl_way;
    logic [4:0]     pl_set;
    logic [TAG_W:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_way][pl_set] <= pl_data;
        for (int w = 0; w < NB_WAYS; w++) begin
            if (tag_req_o[w]) begin
                if (tag_we_o) mem[w][tag_addr_o][TAG_W] <= 1'b0;
                else          rd[w] <= mem[w][tag_addr_o];
            end
        end
    end

    generate
        for (genvar w = 0; w < NB_WAYS; w++) begin : g_rd
            assign tag_rdata_i[w*(TAG_W+1) +: (TAG_W+1)] = rd[w];
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [1:0] way, input logic [4:0] set, input logic [TAG_W:0] data);
        pl_way  = way;
        pl_set  = set;
        pl_data = data;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        int n_ack;
        int nv;
        int f_at;
        int s_at;

        rst_i = 1'b1;
        bypass_req_i = 0; flush_req_i = 0; sel_flush_req_i = 0; sel_flush_addr_i = '0;
        fetch_idle_i = 1; hit_i = 0; miss_i = 0; trans_i = 0; cong_i = 0;
        clear_regs_i = 0; enable_regs_i = 0; wrap_inc = 0;
        pl_en = 0; pl_way = '0; pl_set = '0; pl_data = '0;

        // Reset state
        tick(); tick();
        check_val("reset_outputs", {bypass_ack_o, flush_ack_o, sel_flush_ack_o, ctrl_busy_o,
                                    bypass_o, tag_we_o, tag_req_o, tag_addr_o}, 64'h0);
        check_val("reset_counters", {hit_count_o | trans_count_o | miss_count_o | cong_count_o}, 64'h0);
        rst_i = 1'b0;
        tick();

        preload(2'd0, 5'd5,  {1'b1, 23'h000123});
        preload(2'd3, 5'd31, {1'b1, 23'h7FFFFF});

        // Full flush: writes at offsets 2..33, ack at 34
        flush_req_i = 1'b1;
        tick();
        check_val("flush_busy", ctrl_busy_o, 1);
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k >= 2 && k <= 33) begin
                check_val("flush_ctl", {flush_ack_o, tag_we_o, tag_req_o}, {1'b0, 1'b1, 4'hF});
                check_val("flush_addr", tag_addr_o, 64'(k - 2));
            end else if (k == 34) begin
                check_val("flush_ack", {flush_ack_o, tag_we_o, tag_req_o}, {1'b1, 1'b0, 4'h0});
            end else begin
                check_val("flush_first", {flush_ack_o, tag_req_o}, 64'h0);
            end
        end
        tick();
        check_val("flush_busy_end", {ctrl_busy_o, flush_ack_o}, 64'h0);
        n_ack = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (flush_ack_o) n_ack++;
        end
        check_val("flush_no_retrig", n_ack, 0);
        nv = 0;
        for (int w = 0; w < NB_WAYS; w++)
            for (int s = 0; s < NB_SETS; s++)
                if (mem[w][s][TAG_W] === 1'b1) nv++;
        check_val("flush_all_invalid", nv, 0);
        flush_req_i = 1'b0;
        tick();

        // Selective flush hit: set 19, tag 0x0E0000 in way 2
        preload(2'd2, 5'd19, {1'b1, 23'h0E0000});
        sel_flush_addr_i = 32'h1C00_0130;
        sel_flush_req_i  = 1'b1;
        tick();
        check_val("sel_busy", ctrl_busy_o, 1);
        tick();
        check_val("sel_read", {tag_we_o, tag_req_o, tag_addr_o}, {1'b0, 4'hF, 5'd19});
        tick();
        check_val("sel_wait", {sel_flush_ack_o, tag_req_o}, 64'h0);
        tick();
        check_val("sel_write", {sel_flush_ack_o, tag_we_o, tag_req_o, tag_addr_o},
                  {1'b1, 1'b1, 4'b0100, 5'd19});
        tick();
        check_val("sel_after", {sel_flush_ack_o, ctrl_busy_o, tag_req_o}, 64'h0);
        check_val("sel_invalidated", mem[2][19][TAG_W], 0);
        n_ack = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (sel_flush_ack_o) n_ack++;
        end
        check_val("sel_no_retrig", n_ack, 0);
        sel_flush_req_i = 1'b0;
        tick();

        // Selective flush miss: way 1 valid with a different tag
        preload(2'd1, 5'd19, {1'b1, 23'h000001});
        sel_flush_req_i = 1'b1;
        tick(); tick(); tick(); tick();
        check_val("sel_miss", {sel_flush_ack_o, tag_we_o, tag_req_o}, {1'b1, 1'b0, 4'h0});
        tick();
        check_val("sel_miss_kept", mem[1][19][TAG_W], 1);
        sel_flush_req_i = 1'b0;
        tick();

        // Bypass entry with fetch path busy for 5 cycles
        fetch_idle_i = 1'b0;
        bypass_req_i = 1'b1;
        tick();
        check_val("byp_busy0", {ctrl_busy_o, bypass_o, bypass_ack_o}, 3'b100);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_val("byp_drain", {ctrl_busy_o, bypass_o, bypass_ack_o}, 3'b100);
        end
        fetch_idle_i = 1'b1;
        tick();
        check_val("byp_sw", {ctrl_busy_o, bypass_o, bypass_ack_o}, 3'b100);
        tick();
        check_val("byp_on", {ctrl_busy_o, bypass_o, bypass_ack_o}, 3'b011);
        bypass_req_i = 1'b0;
        tick(); tick();
        check_val("byp_exit_mid", {bypass_o, bypass_ack_o}, 2'b11);
        tick();
        check_val("byp_off", {ctrl_busy_o, bypass_o, bypass_ack_o}, 3'b000);

        // Simultaneous flush + sel_flush while in bypass
        bypass_req_i = 1'b1;
        tick(); tick(); tick();
        check_val("byp_on2", bypass_o, 1);
        flush_req_i     = 1'b1;
        sel_flush_req_i = 1'b1;
        f_at = -1;
        s_at = -1;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (flush_ack_o && f_at < 0)     f_at = k;
            if (sel_flush_ack_o && s_at < 0) s_at = k;
        end
        check_val("simul_flush_ack_at", f_at, 34);
        check_val("simul_sel_ack_at", s_at, 39);
        check_val("simul_bypass_kept", {bypass_o, bypass_ack_o}, 2'b11);
        flush_req_i     = 1'b0;
        sel_flush_req_i = 1'b0;
        bypass_req_i    = 1'b0;
        tick(); tick(); tick(); tick();
        check_val("simul_byp_off", bypass_o, 0);

        // Asynchronous reset in the middle of a flush
        flush_req_i = 1'b1;
        tick();
        for (int k = 1; k <= 12; k++) tick();
        check_val("rst_pre_addr", {tag_we_o, tag_addr_o}, {1'b1, 5'd10});
        #1 rst_i = 1'b1;
        #1;
        check_val("rst_async", {bypass_ack_o, flush_ack_o, sel_flush_ack_o, ctrl_busy_o,
                                bypass_o, tag_we_o, tag_req_o, tag_addr_o}, 64'h0);
        n_ack = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (flush_ack_o) n_ack++;
        end
        check_val("rst_no_ack", n_ack, 0);
        rst_i = 1'b0;
        tick(); tick(); tick();
        check_val("rst_restart", {tag_we_o, tag_req_o, tag_addr_o}, {1'b1, 4'hF, 5'd0});
        n_ack = 0;
        for (int k = 0; k < 40 && n_ack == 0; k++) begin
            tick();
            if (flush_ack_o) n_ack++;
        end
        check_val("rst_restart_done", n_ack, 1);
        flush_req_i = 1'b0;
        tick(); tick();

        // Counters: clear in the 5th cycle wins over the hit in that cycle
        enable_regs_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            hit_i        = 1'b1;
            clear_regs_i = (c == 4);
            cong_i       = (c < 2);
            trans_i      = (c >= 5 && c <= 7);
            miss_i       = (c >= 8);
            tick();
        end
        hit_i = 0; clear_regs_i = 0; cong_i = 0; trans_i = 0; miss_i = 0;
        check_val("cnt_hit", hit_count_o, 5);
        check_val("cnt_cong_cleared", cong_count_o, 0);
        check_val("cnt_trans", trans_count_o, 3);
        check_val("cnt_miss", miss_count_o, 2);
        enable_regs_i = 1'b0;
        hit_i = 1'b1;
        tick(); tick(); tick();
        hit_i = 1'b0;
        check_val("cnt_disabled", hit_count_o, 5);

        // Wrap-around at all ones
        wrap_inc = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        check_val("wrap_max", wrap_count, 4'hF);
        tick();
        wrap_inc = 1'b0;
        check_val("wrap_zero", wrap_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
